// File: rtl/ch_unit_pkg.sv
// ch_unit_pkg: sampler/detector state types and CAN bus levels shared across ch_unit
package ch_unit_pkg;
    typedef enum logic [1:0] {S_IDLE, S_S1, S_S2} sample_t;
    typedef enum logic [1:0] {HUNT, FLAG, DELIM} detect_t;
    localparam logic DOMINANT = 1'b0;
    localparam logic RECESSIVE = 1'b1;
endpackage

// File: rtl/can_error_frame_monitor_if.sv
// can_error_frame_monitor_if: RX sample inputs and error-frame status outputs of the monitor
interface can_error_frame_monitor_if #(parameter int CNT_W = 8);
    logic dIn, samplePulse, rateSelector, clearCount;
    logic bitValid, bitValue, errorFrame, flagStart, flagEnd;
    logic [CNT_W-1:0] errorCount;
    modport master(
        output dIn, samplePulse, rateSelector, clearCount,
        input bitValid, bitValue, errorFrame, flagStart, flagEnd, errorCount
    );
    modport slave(
        input dIn, samplePulse, rateSelector, clearCount,
        output bitValid, bitValue, errorFrame, flagStart, flagEnd, errorCount
    );
endinterface

// File: rtl/can_bit_sampler.sv
// can_bit_sampler: resolves one bit per bit time from 1 sample or a 2-of-3 majority vote
module can_bit_sampler
    import ch_unit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic samplePulse,
    input  logic dIn,
    input  logic rateSelector,
    output logic bitValid,
    output logic bitValue
);
    sample_t st;
    logic s0, s1;
    // Mode is implied by the state: only 3-sample bits ever leave S_IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= S_IDLE;
            s0 <= 1'b0;
            s1 <= 1'b0;
            bitValid <= 1'b0;
            bitValue <= 1'b0;
        end else begin
            bitValid <= 1'b0;
            if (samplePulse) begin
                case (st)
                    S_IDLE: begin
                        if (rateSelector) begin
                            s0 <= dIn;
                            st <= S_S1;
                        end else begin
                            bitValue <= dIn;
                            bitValid <= 1'b1;
                        end
                    end
                    S_S1: begin
                        s1 <= dIn;
                        st <= S_S2;
                    end
                    S_S2: begin
                        bitValue <= (s0 & s1) | (s0 & dIn) | (s1 & dIn);
                        bitValid <= 1'b1;
                        st <= S_IDLE;
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/can_error_frame_monitor.sv
// can_error_frame_monitor: detects active error flags and delimiters on resolved CAN bits
module can_error_frame_monitor
    import ch_unit_pkg::*;
#(
    parameter int DOM_THRESH = 6,
    parameter int DELIM_LEN = 8,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic reset,
    can_error_frame_monitor_if.slave bus
);
    localparam logic [3:0] DT = 4'(DOM_THRESH);
    localparam logic [3:0] DL = 4'(DELIM_LEN);
    detect_t st;
    logic [3:0] rc;
    logic fs, fe;
    logic [CNT_W-1:0] cnt;
    can_bit_sampler u_sampler (
        .clk(clk),
        .reset(reset),
        .samplePulse(bus.samplePulse),
        .dIn(bus.dIn),
        .rateSelector(bus.rateSelector),
        .bitValid(bus.bitValid),
        .bitValue(bus.bitValue)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= HUNT;
            rc <= '0;
            fs <= 1'b0;
            fe <= 1'b0;
        end else begin
            fs <= 1'b0;
            fe <= 1'b0;
            if (bus.bitValid) begin
                case (st)
                    HUNT: begin
                        if (bus.bitValue == DOMINANT) begin
                            if (rc + 4'd1 == DT) begin
                                st <= FLAG;
                                rc <= '0;
                                fs <= 1'b1;
                            end else begin
                                rc <= rc + 4'd1;
                            end
                        end else begin
                            rc <= '0;
                        end
                    end
                    FLAG: begin
                        if (bus.bitValue == RECESSIVE) begin
                            st <= DELIM;
                            rc <= 4'd1;
                        end
                    end
                    DELIM: begin
                        if (bus.bitValue == RECESSIVE) begin
                            if (rc + 4'd1 == DL) begin
                                st <= HUNT;
                                rc <= '0;
                                fe <= 1'b1;
                            end else begin
                                rc <= rc + 4'd1;
                            end
                        end else begin
                            // dominant inside the delimiter is a superposed/overload flag, not a new frame
                            st <= FLAG;
                            rc <= '0;
                        end
                    end
                    default: begin
                        st <= HUNT;
                        rc <= '0;
                    end
                endcase
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (bus.clearCount) cnt <= CNT_W'(fs);
        else if (fs && !(&cnt)) cnt <= cnt + CNT_W'(1);
    end
    assign bus.errorFrame = (st != HUNT);
    assign bus.flagStart = fs;
    assign bus.flagEnd = fe;
    assign bus.errorCount = cnt;
endmodule

// File: tb/tb_can_error_frame_monitor.sv
// tb_can_error_frame_monitor: two parameter sets driven in lockstep against a run-length reference model
module tb_can_error_frame_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    can_error_frame_monitor_if #(.CNT_W(8)) ifa ();
    can_error_frame_monitor_if #(.CNT_W(2)) ifb ();
    can_error_frame_monitor #(.DOM_THRESH(6), .DELIM_LEN(8), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    can_error_frame_monitor #(.DOM_THRESH(6), .DELIM_LEN(2), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    int tests = 0, fails = 0;
    localparam int DT = 6;
    int dl[2] = '{8, 2};
    int cmax[2] = '{255, 3};
    logic e_bv, e_bval, mode;
    int ns, sum;
    logic e_ef[2], e_fs[2], e_fe[2];
    int e_cnt[2], dom[2], rec[2];
    logic f;
    initial begin
        ifa.dIn = 1'b1; ifa.samplePulse = 1'b0; ifa.rateSelector = 1'b0; ifa.clearCount = 1'b0;
        ifb.dIn = 1'b1; ifb.samplePulse = 1'b0; ifb.rateSelector = 1'b0; ifb.clearCount = 1'b0;
    end
    function automatic logic [19:0] got();
        return {ifa.bitValid, ifa.bitValue, ifa.errorFrame, ifa.flagStart, ifa.flagEnd, ifa.errorCount,
                ifb.bitValid, ifb.bitValue, ifb.errorFrame, ifb.flagStart, ifb.flagEnd, ifb.errorCount};
    endfunction
    function automatic logic [19:0] expv();
        return {e_bv, e_bval, e_ef[0], e_fs[0], e_fe[0], 8'(e_cnt[0]),
                e_bv, e_bval, e_ef[1], e_fs[1], e_fe[1], 2'(e_cnt[1])};
    endfunction
    task automatic model_clear();
        e_bv = 0; e_bval = 0; mode = 0; ns = 0; sum = 0;
        for (int m = 0; m < 2; m++) begin
            e_ef[m] = 0; e_fs[m] = 0; e_fe[m] = 0; e_cnt[m] = 0; dom[m] = 0; rec[m] = 0;
        end
    endtask
    // drive one clock cycle of inputs and advance the reference model to match the post-edge outputs
    task automatic tick(input logic p, input logic d, input logic r, input logic c, input logic rs);
        @(negedge clk);
        reset = rs;
        ifa.samplePulse = p; ifa.dIn = d; ifa.rateSelector = r; ifa.clearCount = c;
        ifb.samplePulse = p; ifb.dIn = d; ifb.rateSelector = r; ifb.clearCount = c;
        @(posedge clk);
        #1;
        if (rs) begin
            model_clear();
        end else begin
            for (int m = 0; m < 2; m++) begin
                f = e_fs[m];
                e_cnt[m] = c ? int'(f) : (f && e_cnt[m] < cmax[m]) ? e_cnt[m] + 1 : e_cnt[m];
                e_fs[m] = 0;
                e_fe[m] = 0;
                if (e_bv) begin
                    if (!e_ef[m]) begin
                        dom[m] = e_bval ? 0 : dom[m] + 1;
                        if (dom[m] == DT) begin
                            e_ef[m] = 1; e_fs[m] = 1; dom[m] = 0; rec[m] = 0;
                        end
                    end else begin
                        rec[m] = e_bval ? rec[m] + 1 : 0;
                        if (rec[m] == dl[m]) begin
                            e_ef[m] = 0; e_fe[m] = 1; rec[m] = 0; dom[m] = 0;
                        end
                    end
                end
            end
            e_bv = 0;
            if (p) begin
                if (ns == 0) mode = r;
                sum += int'(d);
                ns++;
                if (ns == (mode ? 3 : 1)) begin
                    e_bv = 1;
                    e_bval = mode ? (sum >= 2) : d;
                    ns = 0;
                    sum = 0;
                end
            end
        end
    endtask
    task automatic test_reset();
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 1);
        if (got() !== 20'h0) begin fails++; $display("FAIL reset got=%h exp=%h", got(), 20'h0); end
        tests++;
        tick(0, 1, 0, 0, 0);
        if (got() !== expv()) begin fails++; $display("FAIL reset_release got=%h exp=%h", got(), expv()); end
        tests++;
    endtask
    task automatic test_majority();
        logic [2:0] trip[3] = '{3'b010, 3'b011, 3'b100};
        logic want[3] = '{1'b0, 1'b1, 1'b0};
        tick(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 6; k++) begin
                tick(k % 2 == 0, trip[i][k/2], 1, 0, 0);
                if (got() !== expv()) begin fails++; $display("FAIL majority bit%0d cyc%0d got=%h exp=%h", i, k, got(), expv()); end
                tests++;
                if (k == 4) begin
                    if (ifa.bitValid !== 1'b1 || ifa.bitValue !== want[i]) begin
                        fails++;
                        $display("FAIL majority_value bit%0d got valid=%b val=%b exp valid=1 val=%b", i, ifa.bitValid, ifa.bitValue, want[i]);
                    end
                    tests++;
                end
            end
    endtask
    task automatic send_bits(input string nm, input logic b[$], output int fs_n, output int fe_n, output int ef_hi);
        fs_n = 0; fe_n = 0; ef_hi = 0;
        foreach (b[i])
            for (int k = 0; k < 3; k++) begin
                tick(k == 0, b[i], 0, 0, 0);
                if (got() !== expv()) begin fails++; $display("FAIL %s bit%0d cyc%0d got=%h exp=%h", nm, i, k, got(), expv()); end
                tests++;
                fs_n += int'(ifa.flagStart);
                fe_n += int'(ifa.flagEnd);
                ef_hi += int'(ifa.errorFrame);
            end
    endtask
    task automatic test_flag();
        logic b[$];
        int fs_n, fe_n, ef_hi;
        tick(0, 1, 0, 0, 1);
        b = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        send_bits("flag", b, fs_n, fe_n, ef_hi);
        if (fs_n !== 1 || fe_n !== 1 || ifa.errorCount !== 8'd1 || ifb.errorCount !== 2'd1) begin
            fails++;
            $display("FAIL flag_summary got fs=%0d fe=%0d cntA=%0d cntB=%0d exp 1 1 1 1", fs_n, fe_n, ifa.errorCount, ifb.errorCount);
        end
        tests++;
        if (ef_hi !== 24) begin fails++; $display("FAIL flag_len got=%0d cycles exp=24", ef_hi); end
        tests++;
    endtask
    task automatic test_no_flag();
        logic b[$];
        int fs_n, fe_n, ef_hi;
        tick(0, 1, 0, 0, 1);
        b = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        send_bits("noflag", b, fs_n, fe_n, ef_hi);
        if (fs_n !== 0 || ef_hi !== 0) begin fails++; $display("FAIL noflag got fs=%0d ef=%0d exp 0 0", fs_n, ef_hi); end
        tests++;
    endtask
    task automatic test_superposed();
        logic b[$];
        int fs_n, fe_n, ef_hi;
        tick(0, 1, 0, 0, 1);
        b = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        send_bits("superposed", b, fs_n, fe_n, ef_hi);
        if (fs_n !== 1 || fe_n !== 1 || ifa.errorCount !== 8'd1) begin
            fails++;
            $display("FAIL superposed got fs=%0d fe=%0d cnt=%0d exp 1 1 1", fs_n, fe_n, ifa.errorCount);
        end
        tests++;
    endtask
    task automatic test_saturate();
        logic b[$];
        int fs_n, fe_n, ef_hi;
        tick(0, 1, 0, 0, 1);
        for (int n = 0; n < 5; n++) begin
            b = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
            send_bits("saturate", b, fs_n, fe_n, ef_hi);
        end
        if (ifa.errorCount !== 8'd5 || ifb.errorCount !== 2'd3) begin
            fails++;
            $display("FAIL saturate got cntA=%0d cntB=%0d exp 5 3", ifa.errorCount, ifb.errorCount);
        end
        tests++;
        for (int i = 0; i < 6; i++)
            for (int k = 0; k < 3; k++) begin
                tick(k == 0, 0, 0, e_fs[0], 0);
                if (got() !== expv()) begin fails++; $display("FAIL clear_coincident bit%0d cyc%0d got=%h exp=%h", i, k, got(), expv()); end
                tests++;
            end
        tick(0, 0, 0, 0, 0);
        if (ifa.errorCount !== 8'd1 || ifb.errorCount !== 2'd1) begin
            fails++;
            $display("FAIL clear_coincident_cnt got cntA=%0d cntB=%0d exp 1 1", ifa.errorCount, ifb.errorCount);
        end
        tests++;
        tick(0, 0, 0, 1, 0);
        if (ifa.errorCount !== 8'd0) begin fails++; $display("FAIL clear got=%0d exp=0", ifa.errorCount); end
        tests++;
    endtask
    task automatic test_reset_mid();
        logic b[$];
        int fs_n, fe_n, ef_hi;
        tick(0, 1, 0, 0, 1);
        b = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        send_bits("reset_mid_pre", b, fs_n, fe_n, ef_hi);
        tick(0, 1, 0, 0, 1);
        if (ifa.errorFrame !== 1'b0 || ifa.errorCount !== 8'd0 || ifa.flagEnd !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid got ef=%b cnt=%0d fe=%b exp 0 0 0", ifa.errorFrame, ifa.errorCount, ifa.flagEnd);
        end
        tests++;
        b = '{1, 1, 1, 1, 1};
        send_bits("reset_mid_post", b, fs_n, fe_n, ef_hi);
        if (fe_n !== 0) begin fails++; $display("FAIL reset_mid_residual got fe=%0d exp=0", fe_n); end
        tests++;
    endtask
    task automatic test_back_to_back();
        tick(0, 1, 0, 0, 1);
        for (int k = 0; k < 80; k++) begin
            tick(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
            if (got() !== expv()) begin fails++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", k, got(), expv()); end
            tests++;
        end
    endtask
    task automatic test_random();
        logic d = 1, r = 0;
        tick(0, 1, 0, 0, 1);
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 39) == 0) d = ~d;
            if ($urandom_range(0, 15) == 0) r = ~r;
            tick($urandom_range(0, 2) == 0, d, r, $urandom_range(0, 199) == 0, $urandom_range(0, 2999) == 0);
            if (got() !== expv()) begin fails++; $display("FAIL random cyc%0d got=%h exp=%h", k, got(), expv()); end
            tests++;
        end
    endtask
    initial begin
        model_clear();
        test_reset();
        test_majority();
        test_flag();
        test_no_flag();
        test_superposed();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
